// File: rtl/stream_const_matcher_pkg.sv
// Shared definitions for the stream constant matcher: compare modes and FSM states.
package stream_const_matcher_pkg;

   // Compare mode codes; code 3 is reserved and behaves as EQ.
   localparam logic [1:0] CMP_EQ = 2'd0;
   localparam logic [1:0] CMP_LT = 2'd1;
   localparam logic [1:0] CMP_GT = 2'd2;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_HIT  = 1'b1
   } state_e;

endpackage

// File: rtl/stream_const_matcher_compare.sv
// Combinational masked unsigned compare of a sample against the reference.
module masked_compare
   import stream_const_matcher_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0] data,
   input  logic [WIDTH-1:0] ref_val,
   input  logic [WIDTH-1:0] mask,
   input  logic [1:0]       mode,
   output logic             result
);

   logic [WIDTH-1:0] data_m;
   logic [WIDTH-1:0] ref_m;

   assign data_m = data & mask;
   assign ref_m  = ref_val & mask;

   // Select the comparison operator; reserved mode falls back to equality.
   always_comb begin
      result = 1'b0;
      unique case (mode)
         CMP_LT:  result = (data_m < ref_m);
         CMP_GT:  result = (data_m > ref_m);
         default: result = (data_m == ref_m);
      endcase
   end

endmodule

// File: rtl/stream_const_matcher.sv
// Matches a valid-qualified sample stream against a programmable reference, requires
// RUN_LEN consecutive matches before pulsing hit, and counts hits with saturation.
module stream_const_matcher
   import stream_const_matcher_pkg::*;
#(
   parameter int unsigned   WIDTH       = 4,
   parameter logic [WIDTH-1:0] REF_DEFAULT = WIDTH'(3),
   parameter int unsigned   RUN_LEN     = 3,
   parameter int unsigned   CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_load,
   input  logic [WIDTH-1:0] cfg_ref,
   input  logic [WIDTH-1:0] cfg_mask,
   input  logic [1:0]       cfg_mode,
   input  logic             cnt_clr,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             match,
   output logic             hit,
   output logic             active,
   output logic [CNT_W-1:0] hit_count
);

   localparam int unsigned     RUN_W    = $clog2(RUN_LEN + 1);
   // Run value at which the next match completes the run.
   localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RUN_LEN - 1);

   logic [WIDTH-1:0] ref_q, mask_q;
   logic [1:0]       mode_q;
   state_e           state_q, state_d;
   logic [RUN_W-1:0] run_q, run_d;
   logic             match_q, match_d;
   logic             hit_q, hit_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             cmp;
   logic             accept;

   // A sample arriving alongside a config load is dropped.
   assign accept = in_valid & ~cfg_load;

   masked_compare #(
      .WIDTH (WIDTH)
   ) u_cmp (
      .data    (in_data),
      .ref_val (ref_q),
      .mask    (mask_q),
      .mode    (mode_q),
      .result  (cmp)
   );

   // Configuration registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ref_q  <= REF_DEFAULT;
         mask_q <= '1;
         mode_q <= CMP_EQ;
      end else if (cfg_load) begin
         ref_q  <= cfg_ref;
         mask_q <= cfg_mask;
         mode_q <= cfg_mode;
      end
   end

   // Next-state logic for FSM, run counter, match, hit pulse and hit counter.
   always_comb begin
      state_d = state_q;
      run_d   = run_q;
      hit_d   = 1'b0;
      match_d = match_q;
      cnt_d   = cnt_q;

      if (cfg_load) begin
         state_d = ST_IDLE;
         run_d   = '0;
      end else if (accept) begin
         match_d = cmp;
         unique case (state_q)
            ST_IDLE: begin
               if (!cmp) begin
                  run_d = '0;
               end else if (run_q == RUN_LAST) begin
                  state_d = ST_HIT;
                  hit_d   = 1'b1;
                  run_d   = '0;
               end else begin
                  run_d = run_q + 1'b1;
               end
            end
            ST_HIT: begin
               if (!cmp) begin
                  state_d = ST_IDLE;
                  run_d   = '0;
               end
            end
            default: begin
               state_d = ST_IDLE;
               run_d   = '0;
            end
         endcase
      end

      // Clear wins over a coincident increment.
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (hit_d && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         run_q   <= '0;
         match_q <= 1'b0;
         hit_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         run_q   <= run_d;
         match_q <= match_d;
         hit_q   <= hit_d;
         cnt_q   <= cnt_d;
      end
   end

   assign match     = match_q;
   assign hit       = hit_q;
   assign active    = (state_q == ST_HIT);
   assign hit_count = cnt_q;

endmodule
